pc_fetch_ctrl: RTL

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues imem requests, holds the IF/ID register, handles redirects.
// Latency: a request ack is accepted combinationally (pc_en in that cycle); IF/ID loads at the next edge.
// Backpressure: decode stall blocks new requests; an issued request is held until ack, and is drained after a redirect.
module pc_fetch_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_pc,
  output logic              o_pc_en,
  output logic [31:0]       o_pc_next,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  input  logic              i_stall,
  output logic              o_imem_req,
  output logic [31:0]       o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_instr,
  output logic [31:0]       o_if_pc,
  output logic              o_misalign,
  output logic [CNT_W-1:0]  o_fetch_cnt
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic        req_active;
  logic [31:0] addr_q;

  logic in_fetch;
  logic in_drain;
  logic ack_seen;
  logic redirect_fire;
  logic accept;

  // Request/PC-update decode; reset forces the outward strobes low.
  always_comb begin
    in_fetch      = (state == S_FETCH);
    in_drain      = (state == S_DRAIN);
    o_imem_req    = !i_rst && (in_drain ||
                    (in_fetch && (req_active || !o_if_valid || !i_stall)));
    o_imem_addr   = req_active ? addr_q : i_pc;
    ack_seen      = o_imem_req && i_imem_ack;
    redirect_fire = !i_rst && i_redirect && (in_fetch || in_drain);
    accept        = in_fetch && ack_seen && !i_redirect;
    o_pc_en       = redirect_fire || accept;
    o_pc_next     = redirect_fire ? {i_redirect_pc[31:2], 2'b00}
                                  : o_imem_addr + 32'd4;
    o_misalign    = redirect_fire && (i_redirect_pc[1:0] != 2'b00);
  end

  // Fetch FSM together with the outstanding-request tracker and IF/ID register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_BOOT;
      req_active  <= 1'b0;
      addr_q      <= 32'd0;
      o_if_valid  <= 1'b0;
      o_if_instr  <= '0;
      o_if_pc     <= 32'd0;
      o_fetch_cnt <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (i_redirect) begin
            o_if_valid <= 1'b0;
            // A request already on the bus without its ack must be drained,
            // otherwise its late ack would be taken as the redirect target's data.
            if (o_imem_req && !i_imem_ack) begin
              state      <= S_DRAIN;
              req_active <= 1'b1;
              addr_q     <= o_imem_addr;
            end else begin
              req_active <= 1'b0;
            end
          end else if (accept) begin
            req_active  <= 1'b0;
            o_if_valid  <= 1'b1;
            o_if_instr  <= i_imem_rdata;
            o_if_pc     <= o_imem_addr;
            o_fetch_cnt <= o_fetch_cnt + 1'b1;
          end else begin
            if (o_imem_req) begin
              req_active <= 1'b1;
              addr_q     <= o_imem_addr;
            end
            if (o_if_valid && !i_stall) begin
              o_if_valid <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (i_redirect) begin
            o_if_valid <= 1'b0;
          end else if (i_imem_ack) begin
            req_active <= 1'b0;
            state      <= S_FETCH;
          end
        end
        default: begin
          state <= S_BOOT;
        end
      endcase
    end
  end

endmodule
